// File: rtl/game_timer_scheduler_if.sv
// Bundle that connects the game timer scheduler to its requesters.
//
// Handshake: req[i] is a one-cycle fire-and-forget pulse with no
// backpressure. duration slice i is sampled in the same cycle as req[i].
// cancel[i] is a one-cycle abort pulse. The scheduler answers with a
// one-cycle done[i] pulse to the owner when its wait ends. busy/grant_id/
// remaining describe the current owner, and state exposes the FSM.
//
// Signals:
//   req       requester -> timer  per-requester request pulse
//   duration  requester -> timer  NUM_REQ packed CNT_W-bit durations
//   cancel    requester -> timer  per-requester abort pulse
//   pause     requester -> timer  freeze prescaler and countdown
//   busy      timer -> requester  timer owned (RUN or FIRE)
//   grant_id  timer -> requester  current owner, valid while busy
//   remaining timer -> requester  ticks left for the owner
//   done      timer -> requester  one-cycle completion pulse
//   tick      timer -> requester  one-cycle game-tick pulse
//   state     timer -> requester  FSM state (0 IDLE, 1 RUN, 2 FIRE)
interface game_timer_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 11
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] duration;
  logic [NUM_REQ-1:0]       cancel;
  logic                     pause;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;
  logic [CNT_W-1:0]         remaining;
  logic [NUM_REQ-1:0]       done;
  logic                     tick;
  logic [1:0]               state;

  modport master (
    output req, duration, cancel, pause,
    input  busy, grant_id, remaining, done, tick, state
  );

  modport slave (
    input  req, duration, cancel, pause,
    output busy, grant_id, remaining, done, tick, state
  );
endinterface

// File: rtl/game_timer_scheduler.sv
// Shared countdown timer for the game layer. Several requesters post
// timed waits; one owner at a time is granted round-robin, its duration is
// counted down in game ticks (TICK_DIV clk cycles each), and a one-cycle
// done pulse is returned to that owner.
//
// Ports:
//   clk     system clock
//   resetN  synchronous reset, 1 = reset
//   bus     game_timer_scheduler_if.slave (requests, status, done, tick)
module game_timer_scheduler #(
  parameter int NUM_REQ  = 3,
  parameter int CNT_W    = 11,
  parameter int TICK_DIV = 833333
) (
  input  logic                   clk,
  input  logic                   resetN,
  game_timer_scheduler_if.slave  bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);
  localparam logic [ID_W-1:0] ID_MAX = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIRE = 2'd2
  } state_t;

  state_t             state;
  logic [PS_W-1:0]    ps;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] pending_nxt;
  logic [CNT_W-1:0]   dur_q   [NUM_REQ];
  logic [CNT_W-1:0]   dur_nxt [NUM_REQ];
  logic [CNT_W-1:0]   dur_in  [NUM_REQ];
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    rr_next;
  logic               found;
  logic               busy;
  logic [CNT_W-1:0]   remaining;
  logic [NUM_REQ-1:0] done;
  logic               tick;
  logic               owner_cancel;
  logic               owner_req;
  logic [CNT_W-1:0]   owner_dur;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dur_in[g] = bus.duration[g*CNT_W +: CNT_W];
  end

  assign tick         = (ps == PS_MAX) && !bus.pause && (state == RUN);
  assign rr_next      = (grant_id == ID_MAX) ? '0 : grant_id + ID_W'(1);
  assign owner_cancel = bus.cancel[grant_id];
  assign owner_req    = bus.req[grant_id];
  assign owner_dur    = dur_in[grant_id];

  // Round-robin pick: first pending index starting at rr_ptr, wrapping.
  always_comb begin
    logic [ID_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && pending[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Pending/duration capture. A request from the running owner is a
  // restart handled by the FSM, so it never becomes pending. Cancel is
  // applied last so it wins over a same-cycle request.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_REQ; i++) dur_nxt[i] = dur_q[i];
    if (state == IDLE && found) pending_nxt[winner] = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req[i] && !(state == RUN && int'(grant_id) == i)) begin
        pending_nxt[i] = 1'b1;
        dur_nxt[i]     = dur_in[i];
      end
      if (bus.cancel[i]) pending_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state     <= IDLE;
      ps        <= '0;
      pending   <= '0;
      for (int i = 0; i < NUM_REQ; i++) dur_q[i] <= '0;
      rr_ptr    <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      remaining <= '0;
      done      <= '0;
    end else begin
      pending <= pending_nxt;
      for (int i = 0; i < NUM_REQ; i++) dur_q[i] <= dur_nxt[i];
      done <= '0;
      if (!bus.pause) ps <= (ps == PS_MAX) ? '0 : ps + PS_W'(1);

      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= winner;
            busy     <= 1'b1;
            if (dur_q[winner] != '0) begin
              state     <= RUN;
              remaining <= dur_q[winner];
              ps        <= '0;
            end else begin
              // Zero-length wait completes without entering RUN.
              state        <= FIRE;
              remaining    <= '0;
              done[winner] <= 1'b1;
            end
          end
        end

        RUN: begin
          if (owner_cancel) begin
            state     <= IDLE;
            busy      <= 1'b0;
            remaining <= '0;
            rr_ptr    <= rr_next;
          end else if (owner_req) begin
            // Restart overrides any tick this cycle.
            ps <= '0;
            if (owner_dur != '0) begin
              remaining <= owner_dur;
            end else begin
              state          <= FIRE;
              remaining      <= '0;
              done[grant_id] <= 1'b1;
            end
          end else if (tick) begin
            if (remaining == CNT_W'(1)) begin
              state          <= FIRE;
              remaining      <= '0;
              done[grant_id] <= 1'b1;
            end else begin
              remaining <= remaining - CNT_W'(1);
            end
          end
        end

        FIRE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          rr_ptr <= rr_next;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.grant_id  = grant_id;
  assign bus.remaining = remaining;
  assign bus.done      = done;
  assign bus.tick      = tick;
  assign bus.state     = state;
endmodule
